// File: rtl/accel_dispatcher_if.sv
// Bundle of every non-clock/reset signal of accel_dispatcher.
//   s_*   : job stream into the dispatcher (valid/ready), operands a and b
//   m_*   : result stream out of the dispatcher (valid/ready), y and abort flag
//   acc_* : wires to the 8-bit sqrt/cbrt accelerator (start strobe, operands, busy, y)
//   busy  : dispatcher has queued or in-flight work
// Modport slave is the dispatcher's view (it is the slave of the job stream);
// modport master is the view of the environment that feeds it and hosts the accelerator.
`timescale 1ns/1ps
interface accel_dispatcher_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_a;
  logic [7:0] s_b;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_y;
  logic       m_err;
  logic       acc_start;
  logic [7:0] acc_a;
  logic [7:0] acc_b;
  logic       acc_busy;
  logic [7:0] acc_y;
  logic       busy;

  modport slave (
    input  s_valid, s_a, s_b, m_ready, acc_busy, acc_y,
    output s_ready, m_valid, m_y, m_err, acc_start, acc_a, acc_b, busy
  );

  modport master (
    output s_valid, s_a, s_b, m_ready, acc_busy, acc_y,
    input  s_ready, m_valid, m_y, m_err, acc_start, acc_a, acc_b, busy
  );
endinterface

// File: rtl/accel_dispatcher.sv
// accel_dispatcher: feeds (a,b) jobs to an 8-bit accelerator computing
// y = floor(sqrt(a + cbrt(b))), whose reset input doubles as its start strobe.
// Jobs are queued in a FIFO_DEPTH-entry FIFO, issued one at a time with a one-cycle
// start pulse, and results are returned in order.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset; also forces acc_start high so the
//            accelerator is re-initialised together with the dispatcher
//   bus    : accel_dispatcher_if.slave
//            s_valid/s_ready/s_a/s_b         job input
//            m_valid/m_ready/m_y/m_err       result output
//            acc_start/acc_a/acc_b           to accelerator (rst_i, a_in, b_in)
//            acc_busy/acc_y                  from accelerator (busy_out, y_out)
//            busy                            FIFO non-empty or FSM not idle
// Build option: define ACC_DISPATCH_TIMEOUT_EN to add a WAIT watchdog that aborts a job
// after TIMEOUT_CYCLES WAIT cycles and returns y=8'hFF with m_err=1. Without it m_err is 0
// and WAIT waits indefinitely.
`timescale 1ns/1ps
module accel_dispatcher #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  accel_dispatcher_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
  begin : g_param_check
    $error("accel_dispatcher: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES > 0");
  end

  typedef enum logic [2:0] {StIdle, StStart, StWait, StOut, StFlush} state_e;

  state_e          state_q;
  logic [7:0]      fifo_a_q [FIFO_DEPTH];
  logic [7:0]      fifo_b_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, push, pop;

  logic            start_q;
  logic            first_q;   // first WAIT cycle: accelerator busy may still be rising
  logic [7:0]      acc_a_q, acc_b_q;
  logic            m_valid_q;
  logic [7:0]      m_y_q;

  // FIFO status is based on the registered count only, so a job pushed into an
  // empty FIFO cannot be popped in the same cycle and a pop never frees a slot
  // for a same-cycle push.
  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.s_valid & bus.s_ready;
  assign pop   = (state_q == StIdle) & ~empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= bus.s_a;
      fifo_b_q[wr_ptr_q] <= bus.s_b;
    end
  end

`ifdef ACC_DISPATCH_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmrW-1:0] timer_q;
  logic            m_err_q;
  logic            timeout;

  // timer_q counts completed WAIT cycles, so this fires in the TIMEOUT_CYCLES-th one.
  assign timeout = (timer_q == TmrW'(TIMEOUT_CYCLES - 1));
  assign bus.m_err = m_err_q;
`else
  assign bus.m_err = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFlush;
      start_q   <= 1'b0;
      first_q   <= 1'b0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      m_valid_q <= 1'b0;
      m_y_q     <= '0;
`ifdef ACC_DISPATCH_TIMEOUT_EN
      timer_q   <= '0;
      m_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFlush: begin
          // Let the accelerator finish whatever the reset left running; its y is dropped.
          if (!bus.acc_busy) state_q <= StIdle;
        end
        StIdle: begin
          if (pop) begin
            acc_a_q <= fifo_a_q[rd_ptr_q];
            acc_b_q <= fifo_b_q[rd_ptr_q];
            start_q <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          start_q <= 1'b0;
          first_q <= 1'b1;
`ifdef ACC_DISPATCH_TIMEOUT_EN
          timer_q <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          first_q <= 1'b0;
`ifdef ACC_DISPATCH_TIMEOUT_EN
          timer_q <= timer_q + 1'b1;
`endif
          if (!first_q && !bus.acc_busy) begin
            m_y_q     <= bus.acc_y;
            m_valid_q <= 1'b1;
            state_q   <= StOut;
          end
`ifdef ACC_DISPATCH_TIMEOUT_EN
          else if (timeout) begin
            // Abandon the job; the next start pulse re-initialises the accelerator.
            m_y_q     <= 8'hFF;
            m_err_q   <= 1'b1;
            m_valid_q <= 1'b1;
            state_q   <= StOut;
          end
`endif
        end
        StOut: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
`ifdef ACC_DISPATCH_TIMEOUT_EN
            m_err_q   <= 1'b0;
`endif
            state_q   <= StIdle;
          end
        end
        default: state_q <= StFlush;
      endcase
    end
  end

  assign bus.s_ready   = ~rst_i & ~full;
  assign bus.acc_start = rst_i | start_q;
  assign bus.acc_a     = acc_a_q;
  assign bus.acc_b     = acc_b_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_y       = m_y_q;
  assign bus.busy      = ~empty | (state_q != StIdle);

endmodule

// File: tb/tb_accel_dispatcher.sv
// Directed bench for accel_dispatcher with a behavioural accelerator attached.
`timescale 1ns/1ps
module tb_accel_dispatcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accel_dispatcher_if bus ();

  accel_dispatcher #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Behavioural accelerator: start strobe restarts it; busy for acc_lat cycles.
  int unsigned acc_lat    = 40;
  int unsigned acc_cnt    = 0;
  logic        acc_busy_m = 1'b0;
  logic [7:0]  acc_y_m    = 8'h00;
  logic [7:0]  acc_a_m    = 8'h00;
  logic [7:0]  acc_b_m    = 8'h00;

  assign bus.acc_busy = acc_busy_m;
  assign bus.acc_y    = acc_y_m;

  function automatic logic [7:0] acc_fn(input logic [7:0] a, input logic [7:0] b);
    int c = 0;
    int r = 0;
    int s;
    while ((c + 1) * (c + 1) * (c + 1) <= int'(b)) c++;
    s = int'(a) + c;
    while ((r + 1) * (r + 1) <= s) r++;
    return 8'(r);
  endfunction

  always @(posedge clk) begin
    if (bus.acc_start) begin
      acc_busy_m <= 1'b1;
      acc_cnt    <= acc_lat;
      acc_a_m    <= bus.acc_a;
      acc_b_m    <= bus.acc_b;
      acc_y_m    <= 8'h00;
    end else if (acc_busy_m) begin
      if (acc_cnt <= 1) begin
        acc_busy_m <= 1'b0;
        acc_y_m    <= acc_fn(acc_a_m, acc_b_m);
      end else begin
        acc_cnt <= acc_cnt - 1;
      end
    end
  end

  // Monitors, sampled mid-cycle.
  int         starts        = 0;
  int         overlaps      = 0;
  bit         allow_overlap = 1'b0;
  logic [7:0] got_y[$];
  logic       got_err[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.acc_start) begin
        starts++;
        if (acc_busy_m && !allow_overlap) overlaps++;
      end
      if (bus.m_valid && bus.m_ready) begin
        got_y.push_back(bus.m_y);
        got_err.push_back(bus.m_err);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bit acc;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    do begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 2000);
    bus.s_valid = 1'b0;
    if (!acc) check("push_accepted", 0, 1);
  endtask

  task automatic wait_mvalid(input int max, input string name);
    int n = 0;
    while (!bus.m_valid && n < max) begin
      step(1);
      n++;
    end
    check(name, int'(bus.m_valid), 1);
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (bus.busy && n < max) begin
      step(1);
      n++;
    end
    check(name, int'(bus.busy), 0);
  endtask

  task automatic wait_results(input int cnt, input int max, input string name);
    int n = 0;
    while (got_y.size() < cnt && n < max) begin
      step(1);
      n++;
    end
    check(name, got_y.size(), cnt);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int bad;
    int lim;
    // y = floor(sqrt(a + floor(cbrt(b))))
    vecs[0] = '{a: 8'd22,  b: 8'd27,  y: 8'd5};   // 22+3=25
    vecs[1] = '{a: 8'd60,  b: 8'd64,  y: 8'd8};   // 60+4=64
    vecs[2] = '{a: 8'd100, b: 8'd125, y: 8'd10};  // 100+5=105
    vecs[3] = '{a: 8'd0,   b: 8'd0,   y: 8'd0};
    vecs[4] = '{a: 8'd255, b: 8'd255, y: 8'd16};  // 255+6=261
    vecs[5] = '{a: 8'd1,   b: 8'd7,   y: 8'd1};   // 1+1=2
    vecs[6] = '{a: 8'd3,   b: 8'd8,   y: 8'd2};   // 3+2=5
    vecs[7] = '{a: 8'd200, b: 8'd1,   y: 8'd14};  // 200+1=201

    bus.s_valid = 1'b0;
    bus.s_a     = 8'h00;
    bus.s_b     = 8'h00;
    bus.m_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    step(3);
    @(negedge clk);
    check("rst_s_ready", int'(bus.s_ready), 0);
    check("rst_acc_start", int'(bus.acc_start), 1);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_m_y", int'(bus.m_y), 0);
    check("rst_m_err", int'(bus.m_err), 0);
    check("rst_acc_a", int'(bus.acc_a), 0);
    check("rst_acc_b", int'(bus.acc_b), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_acc_start", int'(bus.acc_start), 0);
    check("post_rst_s_ready", int'(bus.s_ready), 1);
    check("post_rst_flush_busy", int'(bus.busy), 1);
    wait_idle(200, "flush_done");

    // 1: single job, start pulse timing and operands
    s0 = starts;
    push(8'd22, 8'd27);
    check("t1_no_start_push_cycle", int'(bus.acc_start), 0);
    step(1);
    check("t1_start_pulse", int'(bus.acc_start), 1);
    check("t1_acc_a", int'(bus.acc_a), 22);
    check("t1_acc_b", int'(bus.acc_b), 27);
    step(1);
    check("t1_start_one_cycle", int'(bus.acc_start), 0);
    check("t1_acc_a_hold", int'(bus.acc_a), 22);
    wait_mvalid(200, "t1_m_valid");
    check("t1_m_y", int'(bus.m_y), 5);
    check("t1_m_err", int'(bus.m_err), 0);
    check("t1_starts", starts - s0, 1);
    bus.m_ready = 1'b1;
    step(1);
    bus.m_ready = 1'b0;
    check("t1_m_valid_cleared", int'(bus.m_valid), 0);
    wait_idle(20, "t1_idle");
    got_y.delete();
    got_err.delete();

    // 2: three jobs back-to-back, results in order
    s0 = starts;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(vecs[i].a, vecs[i].b);
    wait_results(3, 600, "t2_result_count");
    for (int i = 0; i < 3 && i < got_y.size(); i++) begin
      check($sformatf("t2_y[%0d]", i), int'(got_y[i]), int'(vecs[i].y));
      check($sformatf("t2_err[%0d]", i), int'(got_err[i]), 0);
    end
    check("t2_starts", starts - s0, 3);
    check("t2_no_overlap", overlaps, 0);
    wait_idle(20, "t2_idle");
    got_y.delete();
    got_err.delete();

    // 3: five jobs with the first in flight fill the FIFO
    s0 = starts;
    push(vecs[3].a, vecs[3].b);
    step(4);
    for (int i = 4; i < 8; i++) push(vecs[i].a, vecs[i].b);
    @(negedge clk);
    check("t3_full_ready_low", int'(bus.s_ready), 0);
    @(posedge clk);
    #1;
    wait_results(5, 1000, "t3_result_count");
    for (int i = 0; i < 5 && i < got_y.size(); i++) begin
      check($sformatf("t3_y[%0d]", i), int'(got_y[i]), int'(vecs[i + 3].y));
      check($sformatf("t3_err[%0d]", i), int'(got_err[i]), 0);
    end
    check("t3_starts", starts - s0, 5);
    check("t3_no_overlap", overlaps, 0);
    wait_idle(20, "t3_idle");
    got_y.delete();
    got_err.delete();

    // 4: result held while m_ready is low; queued job must not start
    bus.m_ready = 1'b0;
    push(8'd60, 8'd64);
    wait_mvalid(200, "t4_m_valid");
    push(8'd22, 8'd27);
    s0  = starts;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.m_valid !== 1'b1 || bus.m_y !== 8'd8) bad++;
    end
    check("t4_out_hold_stable", bad, 0);
    check("t4_no_start_in_out", starts - s0, 0);
    check("t4_busy", int'(bus.busy), 1);
    bus.m_ready = 1'b1;
    wait_results(2, 300, "t4_result_count");
    if (got_y.size() >= 2) begin
      check("t4_y0", int'(got_y[0]), 8);
      check("t4_y1", int'(got_y[1]), 5);
    end
    check("t4_starts", starts - s0, 1);
    wait_idle(20, "t4_idle");
    got_y.delete();
    got_err.delete();

    // 5: reset mid-WAIT with two jobs queued
    s0 = starts;
    push(8'd100, 8'd125);
    push(8'd22, 8'd27);
    push(8'd60, 8'd64);
    step(4);
    rst = 1'b1;
    step(2);
    @(negedge clk);
    check("t5_rst_m_valid", int'(bus.m_valid), 0);
    check("t5_rst_acc_start", int'(bus.acc_start), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t5_fifo_empty_ready", int'(bus.s_ready), 1);
    check("t5_flush_busy", int'(bus.busy), 1);
    wait_idle(200, "t5_flush_done");
    check("t5_no_results", got_y.size(), 0);
    check("t5_starts_before_rst", starts - s0, 1);
    push(8'd60, 8'd64);
    wait_results(1, 200, "t5_result_count");
    if (got_y.size() >= 1) check("t5_y", int'(got_y[0]), 8);
    wait_idle(20, "t5_idle");
    got_y.delete();
    got_err.delete();

`ifdef ACC_DISPATCH_TIMEOUT_EN
    // 6: watchdog abort, then a normal job
    bus.m_ready   = 1'b0;
    acc_lat       = 300;
    allow_overlap = 1'b1;
    push(8'd1, 8'd7);
    lim = 0;
    while (!bus.acc_start && lim < 10) begin
      step(1);
      lim++;
    end
    check("t6_start_seen", int'(bus.acc_start), 1);
    lim = 0;
    while (!bus.m_valid && lim < 400) begin
      step(1);
      lim++;
    end
    check("t6_timeout_latency", lim, 256);
    check("t6_m_y", int'(bus.m_y), 255);
    check("t6_m_err", int'(bus.m_err), 1);
    bus.m_ready = 1'b1;
    step(1);
    bus.m_ready = 1'b0;
    acc_lat     = 40;
    push(8'd22, 8'd27);
    wait_mvalid(200, "t6_next_m_valid");
    check("t6_next_y", int'(bus.m_y), 5);
    check("t6_next_err", int'(bus.m_err), 0);
    bus.m_ready = 1'b1;
    step(1);
    bus.m_ready   = 1'b0;
    allow_overlap = 1'b0;
`else
    lim = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
